// File: rtl/map_ram_pkg.sv
// Shared constants and types for the map RAM port-B arbiter.
package map_ram_pkg;

  localparam int NUM_REQ = 3;
  localparam int ROW_W   = 160;
  localparam int ADDR_W  = 5;

  // Requester slots on the arbiter.
  typedef enum logic [1:0] {
    REQ_SPRITE = 2'd0,
    REQ_PILL   = 2'd1,
    REQ_RELOAD = 2'd2
  } req_idx_e;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the one-hot winner of req, searching from the
// slot after ptr and wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win
);

  // cand[k] is the k-th slot visited, starting just after the pointer.
  logic [PTR_W-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = PTR_W'((32'(ptr) + 32'(gi) + 32'd1) % 32'(N));
  end

  // First requesting slot in search order wins.
  always_comb begin
    win = '0;
    for (int k = 0; k < N; k++) begin
      if (win == '0 && req[cand[k]]) begin
        win[cand[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_ram_arbiter.sv
// Arbitrates map RAM port B between the sprite writer, pill scanner and map
// reload. One owner at a time, round-robin fairness, one drain cycle between
// owners, and a hold limit that forcibly releases a stuck requester.
module map_ram_arbiter
  import map_ram_pkg::ROW_W, map_ram_pkg::ADDR_W, map_ram_pkg::arb_state_e,
         map_ram_pkg::IDLE, map_ram_pkg::GRANT, map_ram_pkg::DRAIN;
#(
  parameter int MAX_HOLD = 64,
  parameter int NUM_REQ  = map_ram_pkg::NUM_REQ
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][ROW_W-1:0]   req_wrdata,
  input  logic [NUM_REQ-1:0]              req_wren,
  input  logic [ROW_W-1:0]                ram_q,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rd_valid,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [ROW_W-1:0]                ram_wrdata,
  output logic                            ram_wren,
  output logic [ROW_W-1:0]                rddata,
  output logic                            timeout_err
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [NUM_REQ-1:0]  mask_q, mask_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;

  logic [NUM_REQ-1:0]  req_open;
  logic [NUM_REQ-1:0]  win;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    owner_idx;
  logic [HOLD_W-1:0]   hold_inc;
  logic                owner_req;

  // Requesters released by timeout stay out of arbitration until they drop req.
  assign req_open  = req & ~mask_q;
  assign owner_req = |(req & gnt_q);
  assign hold_inc  = hold_q + 1'b1;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req_open),
    .ptr (ptr_q),
    .win (win)
  );

  // Convert the one-hot winner and current owner into indices.
  always_comb begin
    win_idx   = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i])   win_idx   = PTR_W'(i);
      if (gnt_q[i]) owner_idx = PTR_W'(i);
    end
  end

  // Next-state logic: arbitrate in IDLE, hold/timeout in GRANT, one DRAIN cycle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    mask_d    = mask_q & req;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        hold_d = '0;
        if (|win) begin
          gnt_d   = win;
          ptr_d   = win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          gnt_d   = '0;
          hold_d  = '0;
          state_d = DRAIN;
        end else if (hold_inc == HOLD_W'(MAX_HOLD)) begin
          // Owner has used its full allowance: evict and mask it.
          gnt_d     = '0;
          hold_d    = '0;
          mask_d    = mask_d | gnt_q;
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          hold_d = hold_inc;
        end
      end
      DRAIN: begin
        gnt_d   = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
    // Read data is only meaningful when the same owner issued last cycle's address.
    rd_valid_d = gnt_d & gnt_q;
  end

  // State registers with synchronous reset; pointer starts so requester 0 wins first.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      mask_q     <= '0;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      hold_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
    end
  end

  // Port-B mux: only the owner's inputs reach the RAM, and only while in GRANT.
  always_comb begin
    ram_addr   = '0;
    ram_wrdata = '0;
    ram_wren   = 1'b0;
    if (state_q == GRANT) begin
      ram_addr   = req_addr[owner_idx];
      ram_wrdata = req_wrdata[owner_idx];
      ram_wren   = req_wren[owner_idx];
    end
  end

  assign gnt         = gnt_q;
  assign rd_valid    = rd_valid_q;
  assign timeout_err = timeout_q;
  assign rddata      = ram_q;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter with a small port-B RAM model.
module tb_map_ram_arbiter;

  logic                clk;
  logic                reset;
  logic [2:0]          req;
  logic [2:0][4:0]     req_addr;
  logic [2:0][159:0]   req_wrdata;
  logic [2:0]          req_wren;
  logic [159:0]        ram_q;
  logic [2:0]          gnt;
  logic [2:0]          rd_valid;
  logic [4:0]          ram_addr;
  logic [159:0]        ram_wrdata;
  logic                ram_wren;
  logic [159:0]        rddata;
  logic                timeout_err;

  logic [159:0] mem [32] = '{default: '0};

  typedef struct packed {
    logic [2:0]   gnt;
    logic [2:0]   rdv;
    logic         wren;
    logic [4:0]   addr;
    logic [159:0] data;
    logic         to;
  } exp_t;

  exp_t  eq [$];
  string tq [$];
  int    n_assert = 0;
  int    n_fail   = 0;

  map_ram_arbiter #(.MAX_HOLD(4)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .req_wrdata  (req_wrdata),
    .req_wren    (req_wren),
    .ram_q       (ram_q),
    .gnt         (gnt),
    .rd_valid    (rd_valid),
    .ram_addr    (ram_addr),
    .ram_wrdata  (ram_wrdata),
    .ram_wren    (ram_wren),
    .rddata      (rddata),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B RAM: registered read, read-before-write.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wrdata;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, push expectations, compare at negedge.
  task automatic cyc(input logic rst, input logic [2:0] r, input logic [2:0] we,
                     input int own, input logic [2:0] rdv, input logic to, input string tag);
    exp_t       e;
    exp_t       o;
    string      t;
    logic [1:0] oi;
    @(posedge clk);
    #1;
    reset    = rst;
    req      = r;
    req_wren = we;
    e = '0;
    e.rdv = rdv;
    e.to  = to;
    if (own >= 0) begin
      oi       = own[1:0];
      e.gnt    = 3'b001 << oi;
      e.wren   = we[oi];
      e.addr   = req_addr[oi];
      e.data   = req_wrdata[oi];
    end
    eq.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
    o = eq.pop_front();
    t = tq.pop_front();
    check({t, ".gnt"},      160'(gnt),         160'(o.gnt));
    check({t, ".rd_valid"}, 160'(rd_valid),    160'(o.rdv));
    check({t, ".ram_wren"}, 160'(ram_wren),    160'(o.wren));
    check({t, ".ram_addr"}, 160'(ram_addr),    160'(o.addr));
    check({t, ".wrdata"},   ram_wrdata,        o.data);
    check({t, ".timeout"},  160'(timeout_err), 160'(o.to));
    $display("cyc %-12s req=%b wren=%b gnt=%b rdv=%b ram_wren=%b addr=%0d to=%b",
             t, r, we, gnt, rd_valid, ram_wren, ram_addr, timeout_err);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_wren = '0;
    req_addr[0] = 5'd5;
    req_addr[1] = 5'd9;
    req_addr[2] = 5'd17;
    for (int i = 0; i < 3; i++) req_wrdata[i] = {5{32'hC0DE_0000 + 32'(i)}};
    repeat (2) @(posedge clk);

    // Reset state.
    cyc(1, 3'b000, 3'b000, -1, 3'b000, 0, "reset");

    // Single request: wren in grant cycles 2-3.
    cyc(0, 3'b001, 3'b000, -1, 3'b000, 0, "s_idle");
    cyc(0, 3'b001, 3'b000,  0, 3'b000, 0, "s_g1");
    cyc(0, 3'b001, 3'b001,  0, 3'b001, 0, "s_g2");
    cyc(0, 3'b001, 3'b001,  0, 3'b001, 0, "s_g3");
    cyc(0, 3'b000, 3'b000,  0, 3'b001, 0, "s_g4rel");
    cyc(0, 3'b000, 3'b000, -1, 3'b000, 0, "s_drain");
    cyc(0, 3'b000, 3'b000, -1, 3'b000, 0, "s_idle2");

    // Simultaneous requests from reset: 0 -> 1 -> 2 -> 0.
    cyc(1, 3'b000, 3'b000, -1, 3'b000, 0, "m_reset");
    cyc(0, 3'b111, 3'b000, -1, 3'b000, 0, "m_arb0");
    cyc(0, 3'b111, 3'b000,  0, 3'b000, 0, "m_g0");
    cyc(0, 3'b110, 3'b000,  0, 3'b001, 0, "m_g0rel");
    cyc(0, 3'b111, 3'b000, -1, 3'b000, 0, "m_drain0");
    cyc(0, 3'b111, 3'b000, -1, 3'b000, 0, "m_arb1");
    cyc(0, 3'b111, 3'b000,  1, 3'b000, 0, "m_g1");
    cyc(0, 3'b101, 3'b000,  1, 3'b010, 0, "m_g1rel");
    cyc(0, 3'b111, 3'b000, -1, 3'b000, 0, "m_drain1");
    cyc(0, 3'b111, 3'b000, -1, 3'b000, 0, "m_arb2");
    cyc(0, 3'b111, 3'b000,  2, 3'b000, 0, "m_g2");
    cyc(0, 3'b011, 3'b000,  2, 3'b100, 0, "m_g2rel");
    cyc(0, 3'b111, 3'b000, -1, 3'b000, 0, "m_drain2");
    cyc(0, 3'b111, 3'b000, -1, 3'b000, 0, "m_arb0b");
    cyc(0, 3'b000, 3'b000,  0, 3'b000, 0, "m_g0b");
    cyc(0, 3'b000, 3'b000, -1, 3'b000, 0, "m_drain3");

    // Isolation: requester 1 writes while requester 0 owns the port.
    cyc(1, 3'b000, 3'b000, -1, 3'b000, 0, "i_reset");
    cyc(0, 3'b011, 3'b000, -1, 3'b000, 0, "i_arb");
    cyc(0, 3'b011, 3'b010,  0, 3'b000, 0, "i_g1");
    cyc(0, 3'b011, 3'b011,  0, 3'b001, 0, "i_g2");
    cyc(0, 3'b010, 3'b010,  0, 3'b001, 0, "i_g3rel");
    cyc(0, 3'b010, 3'b000, -1, 3'b000, 0, "i_drain");
    check("i_rddata", rddata, req_wrdata[0]);
    cyc(0, 3'b010, 3'b000, -1, 3'b000, 0, "i_arb1");
    cyc(0, 3'b000, 3'b000,  1, 3'b000, 0, "i_g1rel");
    cyc(0, 3'b000, 3'b000, -1, 3'b000, 0, "i_drain1");
    check("i_row9", mem[9], 160'd0);
    check("i_row5", mem[5], req_wrdata[0]);

    // Timeout: requester 2 holds forever, requester 0 waits.
    cyc(1, 3'b000, 3'b000, -1, 3'b000, 0, "t_reset");
    cyc(0, 3'b100, 3'b000, -1, 3'b000, 0, "t_arb2");
    cyc(0, 3'b101, 3'b000,  2, 3'b000, 0, "t_h1");
    cyc(0, 3'b101, 3'b000,  2, 3'b100, 0, "t_h2");
    cyc(0, 3'b101, 3'b000,  2, 3'b100, 0, "t_h3");
    cyc(0, 3'b101, 3'b000,  2, 3'b100, 0, "t_h4");
    cyc(0, 3'b101, 3'b000, -1, 3'b000, 1, "t_drain");
    cyc(0, 3'b101, 3'b000, -1, 3'b000, 1, "t_arb0");
    cyc(0, 3'b101, 3'b000,  0, 3'b000, 1, "t_g0");
    cyc(0, 3'b100, 3'b000,  0, 3'b001, 1, "t_g0rel");
    cyc(0, 3'b100, 3'b000, -1, 3'b000, 1, "t_drain0");
    cyc(0, 3'b100, 3'b000, -1, 3'b000, 1, "t_masked1");
    cyc(0, 3'b100, 3'b000, -1, 3'b000, 1, "t_masked2");
    cyc(0, 3'b000, 3'b000, -1, 3'b000, 1, "t_drop2");
    cyc(0, 3'b100, 3'b000, -1, 3'b000, 1, "t_arb2b");
    cyc(0, 3'b000, 3'b000,  2, 3'b000, 1, "t_g2b");
    cyc(0, 3'b000, 3'b000, -1, 3'b000, 1, "t_drain2");

    // Reset during a write grant.
    cyc(0, 3'b010, 3'b000, -1, 3'b000, 1, "r_arb1");
    cyc(0, 3'b010, 3'b010,  1, 3'b000, 1, "r_g1");
    cyc(1, 3'b010, 3'b010,  1, 3'b010, 1, "r_rst");
    cyc(0, 3'b011, 3'b011, -1, 3'b000, 0, "r_after");
    cyc(0, 3'b001, 3'b000,  0, 3'b000, 0, "r_g0");
    cyc(0, 3'b000, 3'b000,  0, 3'b001, 0, "r_g0rel");
    cyc(0, 3'b000, 3'b000, -1, 3'b000, 0, "r_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/map_ram_arbiter.md
MAP_RAM_ARBITER -- requirements
Module: map_ram_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 64, SHALL be the maximum number of consecutive cycles one requester may hold the grant.
REQ-002 Parameter NUM_REQ, default 3, SHALL be the requester count: 0 = sprite map writer, 1 = pill scanner, 2 = map reload.
REQ-003 CLOCK_50  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be synchronous, active-high.
REQ-005 req  in  NUM_REQ  SHALL be the per-requester access request, held high for the whole transaction.
REQ-006 req_addr  in  NUM_REQ x 5  SHALL be the per-requester map row address.
REQ-007 req_wrdata  in  NUM_REQ x 160  SHALL be the per-requester row write data.
REQ-008 req_wren  in  NUM_REQ  SHALL be the per-requester write enable.
REQ-009 ram_q  in  160  SHALL be map RAM port-B read data, valid one cycle after its address.
REQ-010 gnt  out  NUM_REQ  SHALL be the one-hot (or zero) registered grant.
REQ-011 rd_valid  out  NUM_REQ  SHALL flag that ram_q holds data for the owner's previous-cycle address.
REQ-012 ram_addr  out  5;  ram_wrdata  out  160;  ram_wren  out  1  SHALL drive map RAM port B.
REQ-013 rddata  out  160  SHALL be ram_q passed through unregistered to all requesters.
REQ-014 timeout_err  out  1  SHALL be a sticky flag set on any forced release.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT, DRAIN.
REQ-016 IDLE: if any unmasked req is high, pick the winner round-robin, set gnt to its one-hot and go to GRANT next cycle; else stay IDLE with gnt = 0.
REQ-017 Round-robin SHALL search starting at the index after the last granted requester, wrapping NUM_REQ-1 -> 0.
REQ-018 GRANT: while the owner's req is high, gnt SHALL hold, and the hold counter SHALL increment each cycle.
REQ-019 GRANT -> DRAIN SHALL occur the cycle after the owner's req is sampled low; gnt SHALL be 0 in DRAIN.
REQ-020 DRAIN SHALL last exactly one cycle, with ram_wren = 0, then go to IDLE.
REQ-021 Release-to-next-grant SHALL be 3 cycles: req low at t, DRAIN at t+1, IDLE arbitrates at t+2, gnt at t+3.
REQ-022 Port mux: in GRANT, ram_addr, ram_wrdata and ram_wren SHALL equal the owner's inputs combinationally. Otherwise they SHALL be 0.
REQ-023 req_wren from any non-owner SHALL never reach ram_wren.
REQ-024 rd_valid[i] SHALL be high in cycle t iff gnt[i] was high in both t-1 and t.
REQ-025 If the hold counter reaches MAX_HOLD with req still high, the FSM SHALL force DRAIN and set timeout_err.
REQ-026 After a forced release, that requester SHALL be masked until its req is sampled low.
REQ-027 A requester raising req while another owns the grant SHALL wait; its request is never dropped.
REQ-028 Simultaneous requests in IDLE SHALL be resolved purely by the round-robin pointer.

Reset
REQ-029 On reset: state = IDLE, gnt = 0, rd_valid = 0, hold counter = 0, mask = 0, timeout_err = 0, and the pointer set so requester 0 has highest priority.
REQ-030 Reset mid-GRANT SHALL drop gnt and ram_wren in the cycle following the reset edge, with no DRAIN.

Structure
REQ-031 Package map_ram_pkg SHALL hold NUM_REQ, ROW_W = 160, ADDR_W = 5, the requester index enum and the FSM state typedef.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick: inputs are the request vector and pointer; output is the one-hot winner.

Verification
REQ-033 Single request:
- stimulus: req = 001 in IDLE, addr 5, wren pulses in cycles 2-3 of the grant.
- response: gnt = 001 the next cycle; ram_wren high only in those cycles; rd_valid[0] high from the second grant cycle onward.
REQ-034 Simultaneous requests:
- stimulus: req = 111 from reset.
- response: grants go 0 -> 1 -> 2 -> 0; each release is followed by one DRAIN cycle.
REQ-035 Isolation:
- stimulus: requester 1 asserts wren while requester 0 owns the grant.
- response: ram_wren follows only requester 0; the RAM row written by requester 1 is unchanged.
REQ-036 Timeout:
- stimulus: MAX_HOLD = 4; requester 2 holds req forever while requester 0 also requests.
- response: forced DRAIN after 4 grant cycles; timeout_err = 1; requester 0 is granted next; requester 2 is not re-granted until its req toggles low.
REQ-037 Reset mid-operation:
- stimulus: reset asserted during GRANT with wren = 1.
- response: the next cycle has gnt = 0, ram_wren = 0 and timeout_err = 0; requester 0 is granted first afterward.
